// File: rtl/cart_mem_arbiter_if.sv
// Cartridge memory arbiter bus bundle.
// Carries the three requester ports (CHR, PRG, LDR), the downstream
// SDRAM-controller port and the arbiter status signals.
// slave  = arbiter side, master = requesters/controller side.
interface cart_mem_arbiter_if #(
   parameter int ADDR_W = 21
);
   // CHR port (PPU fetch)
   logic              chr_req;
   logic              chr_we;
   logic [ADDR_W-1:0] chr_addr;
   logic [7:0]        chr_wdata;
   logic              chr_ack;
   logic [7:0]        chr_rdata;
   // PRG port (CPU fetch)
   logic              prg_req;
   logic              prg_we;
   logic [ADDR_W-1:0] prg_addr;
   logic [7:0]        prg_wdata;
   logic              prg_ack;
   logic [7:0]        prg_rdata;
   // LDR port (I2C ROM loader)
   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [7:0]        ldr_wdata;
   logic              ldr_ack;
   logic [7:0]        ldr_rdata;
   // downstream controller
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   // status
   logic              busy;
   logic [1:0]        grant;
   logic              wdog_err;

   modport slave (
      input  chr_req, chr_we, chr_addr, chr_wdata,
      output chr_ack, chr_rdata,
      input  prg_req, prg_we, prg_addr, prg_wdata,
      output prg_ack, prg_rdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_ack, ldr_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output busy, grant, wdog_err
   );

   modport master (
      output chr_req, chr_we, chr_addr, chr_wdata,
      input  chr_ack, chr_rdata,
      output prg_req, prg_we, prg_addr, prg_wdata,
      input  prg_ack, prg_rdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_ack, ldr_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  busy, grant, wdog_err
   );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: three requesters (CHR > PRG > LDR, fixed
// priority) share one SDRAM controller port. One transaction at a time,
// IDLE -> BUSY -> DONE, all outputs registered.
// Optional feature macro: CART_ARB_WATCHDOG_EN -- bounds BUSY to WDOG_CYC
// cycles, answering the requester with 8'hFF and setting sticky wdog_err.
module cart_mem_arbiter #(
   parameter int ADDR_W   = 21,
   parameter int WDOG_CYC = 64
) (
   input logic                 clk_in,
   input logic                 rst_in,
   cart_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // requester index: 0=CHR, 1=PRG, 2=LDR; grant code is index+1
   logic [2:0]             w_req;
   logic [2:0]             w_we;
   logic [2:0][ADDR_W-1:0] w_addr;
   logic [2:0][7:0]        w_wdata;
   logic [1:0]             w_sel;

   state_t                 r_state;
   logic [1:0]             r_sel;
   logic [1:0]             r_grant;
   logic                   r_mem_req;
   logic                   r_mem_we;
   logic [ADDR_W-1:0]      r_mem_addr;
   logic [7:0]             r_mem_wdata;
   logic [2:0]             r_ack;
   logic [2:0][7:0]        r_rdata;
   logic                   r_wdog_err;

   assign w_req   = {bus.ldr_req,   bus.prg_req,   bus.chr_req};
   assign w_we    = {bus.ldr_we,    bus.prg_we,    bus.chr_we};
   assign w_addr  = {bus.ldr_addr,  bus.prg_addr,  bus.chr_addr};
   assign w_wdata = {bus.ldr_wdata, bus.prg_wdata, bus.chr_wdata};

   // fixed-priority winner pick, only meaningful while some req is high
   always_comb begin
      w_sel = 2'd2;
      if (w_req[0])      w_sel = 2'd0;
      else if (w_req[1]) w_sel = 2'd1;
   end

`ifdef CART_ARB_WATCHDOG_EN
   localparam int CNT_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
   logic [CNT_W-1:0] r_wdog_cnt;
`else
   // keeps the watchdog limit referenced when the feature is compiled out
   logic w_unused_wdog;
   assign w_unused_wdog = (WDOG_CYC == 0);
`endif

   // transaction FSM; every bus-facing output is a register set here
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= ST_IDLE;
         r_sel       <= 2'd0;
         r_grant     <= 2'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_ack       <= '0;
         r_rdata     <= '0;
         r_wdog_err  <= 1'b0;
`ifdef CART_ARB_WATCHDOG_EN
         r_wdog_cnt  <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack   <= '0;
               r_grant <= 2'd0;
               // req is a level: whatever is high now wins, late ones wait
               if (|w_req) begin
                  r_sel       <= w_sel;
                  r_grant     <= w_sel + 2'd1;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_we[w_sel];
                  r_mem_addr  <= w_addr[w_sel];
                  r_mem_wdata <= w_wdata[w_sel];
                  r_state     <= ST_BUSY;
`ifdef CART_ARB_WATCHDOG_EN
                  r_wdog_cnt  <= '0;
`endif
               end
            end
            ST_BUSY: begin
               // mem_* held from the latch; requester inputs are ignored here
               if (bus.mem_ack) begin
                  r_mem_req    <= 1'b0;
                  r_ack[r_sel] <= 1'b1;
                  // writes leave the port's last read data in place
                  if (!r_mem_we) r_rdata[r_sel] <= bus.mem_rdata;
                  r_state      <= ST_DONE;
               end
`ifdef CART_ARB_WATCHDOG_EN
               else if (r_wdog_cnt == WDOG_LAST) begin
                  // controller never answered: release the requester with 0xFF
                  r_mem_req      <= 1'b0;
                  r_ack[r_sel]   <= 1'b1;
                  r_rdata[r_sel] <= 8'hFF;
                  r_wdog_err     <= 1'b1;
                  r_state        <= ST_DONE;
               end else begin
                  r_wdog_cnt <= r_wdog_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               // single-cycle ack; mem_ack arriving here is ignored
               r_ack   <= '0;
               r_grant <= 2'd0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ack     <= '0;
               r_grant   <= 2'd0;
               r_mem_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.chr_ack   = r_ack[0];
   assign bus.prg_ack   = r_ack[1];
   assign bus.ldr_ack   = r_ack[2];
   assign bus.chr_rdata = r_rdata[0];
   assign bus.prg_rdata = r_rdata[1];
   assign bus.ldr_rdata = r_rdata[2];
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.grant     = r_grant;
   assign bus.wdog_err  = r_wdog_err;

endmodule
